// File: rtl/ps2_letter_receiver.sv
// PS/2 keyboard front end: receives set-2 frames and turns letter make codes
// into a one-cycle pressed strobe with a 0-25 letter index.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a start bit (PS2_DAT low on edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | sampling the odd-parity bit
// S_STOP   | sampling the stop bit, then validating the byte
module ps2_letter_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       pressed,
    output logic [4:0] inputLetter,
    output logic [7:0] scan_code,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          ps2_clk_s1, ps2_clk_s2, ps2_clk_prev;
    logic          ps2_dat_s1, ps2_dat_s2;
    logic          ps2_fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_ok;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          byte_valid;
    logic          ext_pending, break_pending;
    logic          held_valid;
    logic [7:0]    held_code;
    logic [5:0]    lookup;

    function automatic logic [5:0] letter_lookup(input logic [7:0] code);
        logic [5:0] res;
        res = 6'd0;
        case (code)
            8'h1C: res = {1'b1, 5'd0};
            8'h32: res = {1'b1, 5'd1};
            8'h21: res = {1'b1, 5'd2};
            8'h23: res = {1'b1, 5'd3};
            8'h24: res = {1'b1, 5'd4};
            8'h2B: res = {1'b1, 5'd5};
            8'h34: res = {1'b1, 5'd6};
            8'h33: res = {1'b1, 5'd7};
            8'h43: res = {1'b1, 5'd8};
            8'h3B: res = {1'b1, 5'd9};
            8'h42: res = {1'b1, 5'd10};
            8'h4B: res = {1'b1, 5'd11};
            8'h3A: res = {1'b1, 5'd12};
            8'h31: res = {1'b1, 5'd13};
            8'h44: res = {1'b1, 5'd14};
            8'h4D: res = {1'b1, 5'd15};
            8'h15: res = {1'b1, 5'd16};
            8'h2D: res = {1'b1, 5'd17};
            8'h1B: res = {1'b1, 5'd18};
            8'h2C: res = {1'b1, 5'd19};
            8'h3C: res = {1'b1, 5'd20};
            8'h2A: res = {1'b1, 5'd21};
            8'h1D: res = {1'b1, 5'd22};
            8'h22: res = {1'b1, 5'd23};
            8'h35: res = {1'b1, 5'd24};
            8'h1A: res = {1'b1, 5'd25};
            default: res = 6'd0;
        endcase
        return res;
    endfunction

    // Synchronisers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_s1   <= 1'b1;
            ps2_clk_s2   <= 1'b1;
            ps2_clk_prev <= 1'b1;
            ps2_dat_s1   <= 1'b1;
            ps2_dat_s2   <= 1'b1;
        end else begin
            ps2_clk_s1   <= PS2_CLK;
            ps2_clk_s2   <= ps2_clk_s1;
            ps2_clk_prev <= ps2_clk_s2;
            ps2_dat_s1   <= PS2_DAT;
            ps2_dat_s2   <= ps2_dat_s1;
        end
    end

    assign ps2_fall = ps2_clk_prev & ~ps2_clk_s2;
    assign tmo_hit  = (state != S_IDLE) && !ps2_fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_ok   <= 1'b0;
            tmo_cnt     <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (ps2_fall || state == S_IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (tmo_hit) begin
                state       <= S_IDLE;
                frame_error <= 1'b1;
            end else if (ps2_fall) begin
                case (state)
                    S_IDLE: begin
                        if (!ps2_dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_reg <= {ps2_dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_ok <= ^{shift_reg, ps2_dat_s2};
                        state     <= S_STOP;
                    end
                    default: begin
                        if (ps2_dat_s2 && parity_ok) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // shift_reg is stable while byte_valid is high: the next frame's data edges are far away.
    assign lookup = letter_lookup(shift_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed       <= 1'b0;
            inputLetter   <= 5'd0;
            scan_code     <= 8'h00;
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
            held_valid    <= 1'b0;
            held_code     <= 8'h00;
        end else begin
            pressed <= 1'b0;
            if (byte_valid) begin
                scan_code <= shift_reg;
                if (shift_reg == 8'hE0) begin
                    ext_pending <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    break_pending <= 1'b1;
                end else if (break_pending) begin
                    if (held_valid && shift_reg == held_code) begin
                        held_valid <= 1'b0;
                    end
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else if (ext_pending) begin
                    ext_pending <= 1'b0;
                end else if (lookup[5] && !(held_valid && shift_reg == held_code)) begin
                    pressed     <= 1'b1;
                    inputLetter <= lookup[4:0];
                    held_valid  <= 1'b1;
                    held_code   <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_letter_receiver.sv
// Directed bench for ps2_letter_receiver: bit-bangs PS/2 frames and checks
// strobe counts, letter index, scan code and error behaviour.
module tb_ps2_letter_receiver;

    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clk;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       pressed;
    logic [4:0] inputLetter;
    logic [7:0] scan_code;
    logic       frame_error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int press_cnt   = 0;
    int err_cnt     = 0;
    int wide_cnt    = 0;
    int both_cnt    = 0;
    int press_cyc   = 0;
    int stop_cyc    = 0;
    int p0, e0;
    logic [4:0] last_letter = 5'd0;
    logic pressed_q = 1'b0;
    logic ferr_q    = 1'b0;

    ps2_letter_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .pressed     (pressed),
        .inputLetter (inputLetter),
        .scan_code   (scan_code),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pressed) begin
            press_cnt++;
            last_letter = inputLetter;
            press_cyc   = cyc;
            if (pressed_q) wide_cnt++;
        end
        if (frame_error) begin
            err_cnt++;
            if (ferr_q) wide_cnt++;
        end
        if (pressed && frame_error) both_cnt++;
        pressed_q = pressed;
        ferr_q    = frame_error;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = fr[i];
            repeat (HALF) @(posedge clk);
            #2;
            PS2_CLK = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(posedge clk);
            #2;
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(mk_frame(b, bad), 11);
        repeat (3 * HALF) @(posedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_letter", int'(inputLetter), 0);
        chk("rst_scan", int'(scan_code), 0);
        chk("rst_ferr", int'(frame_error), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // single letter
        p0 = press_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0);
        chk("single_press", press_cnt - p0, 1);
        chk("single_letter", int'(last_letter), 0);
        chk("single_scan", int'(scan_code), 8'h1C);
        chk("single_err", err_cnt - e0, 0);
        chk("single_latency", int'((press_cyc - stop_cyc) >= 1 && (press_cyc - stop_cyc) <= 6), 1);

        // typematic and release
        do_reset();
        p0 = press_cnt;
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("typematic_press", press_cnt - p0, 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("release_press", press_cnt - p0, 1);
        send_byte(8'h1C, 1'b0);
        chk("repress_press", press_cnt - p0, 2);
        chk("repress_letter", int'(last_letter), 0);

        // parity error
        do_reset();
        p0 = press_cnt; e0 = err_cnt;
        send_byte(8'h1A, 1'b1);
        chk("parity_err", err_cnt - e0, 1);
        chk("parity_press", press_cnt - p0, 0);
        chk("parity_scan", int'(scan_code), 8'h00);
        send_byte(8'h1A, 1'b0);
        chk("after_parity_press", press_cnt - p0, 1);
        chk("after_parity_letter", int'(last_letter), 25);
        chk("after_parity_scan", int'(scan_code), 8'h1A);

        // timeout
        do_reset();
        p0 = press_cnt; e0 = err_cnt;
        send_bits(mk_frame(8'h4D, 1'b0), 5);
        repeat (TMO + 10) @(posedge clk);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_press", press_cnt - p0, 0);
        send_byte(8'h4D, 1'b0);
        chk("after_tmo_press", press_cnt - p0, 1);
        chk("after_tmo_letter", int'(last_letter), 15);
        chk("after_tmo_err", err_cnt - e0, 1);

        // extended and non-letter keys
        do_reset();
        p0 = press_cnt; e0 = err_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("ext_scan", int'(scan_code), 8'h75);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'h29, 1'b0);
        chk("nonletter_scan29", int'(scan_code), 8'h29);
        send_byte(8'h45, 1'b0);
        chk("nonletter_scan45", int'(scan_code), 8'h45);
        chk("ext_press", press_cnt - p0, 0);
        chk("ext_err", err_cnt - e0, 0);

        // reset mid-frame
        p0 = press_cnt; e0 = err_cnt;
        send_bits(mk_frame(8'h24, 1'b0), 6);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_pressed", int'(pressed), 0);
        chk("midrst_letter", int'(inputLetter), 0);
        chk("midrst_scan", int'(scan_code), 0);
        chk("midrst_ferr", int'(frame_error), 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        send_byte(8'h24, 1'b0);
        chk("midrst_press", press_cnt - p0, 1);
        chk("midrst_letter_e", int'(last_letter), 4);
        chk("midrst_err", err_cnt - e0, 0);

        chk("strobe_width", wide_cnt, 0);
        chk("strobe_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
